// File: rtl/afe_spi_writer.sv
// Write-only serial driver for the AFE attenuator/switch control lanes.
// Shifts one command MSB-first to the selected lane, then pulses LE.
module afe_spi_writer #(
  parameter int CLK_RATE  = 99999001,
  parameter int SPI_RATE  = 10000000,
  parameter int AFE_COUNT = 2
) (
  input  logic                 sysClk,
  input  logic                 sysReset,
  input  logic                 writeStrobe,
  input  logic [31:0]          writeData,
  output logic [31:0]          status,
  output logic [AFE_COUNT-1:0] AFE_SPI_CLK,
  output logic [AFE_COUNT-1:0] AFE_SPI_SDI,
  output logic [AFE_COUNT-1:0] AFE_SPI_LE
);

  localparam int H_RAW = (CLK_RATE + 2 * SPI_RATE - 1) / (2 * SPI_RATE);
  localparam int H     = (H_RAW < 1) ? 1 : H_RAW;
  localparam int HW    = (H > 1) ? $clog2(H) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(H - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LE_SETUP,
    LATCH,
    GAP
  } state_t;

  state_t               state;
  logic [HW-1:0]        half_cnt;
  logic [4:0]           bit_cnt;
  logic [23:0]          shreg;
  logic [AFE_COUNT-1:0] lane_mask;
  logic                 busy;
  logic                 overrun;
  logic [1:0]           last_lane;
  logic [23:0]          last_data;

  logic [1:0]           wd_lane;
  logic [4:0]           wd_count;
  logic [23:0]          wd_data;
  logic [23:0]          wd_load;
  logic [AFE_COUNT-1:0] wd_mask;
  logic                 cmd_ok;
  logic                 half_done;

  always_comb begin
    wd_lane   = writeData[31:30];
    wd_count  = writeData[28:24];
    wd_data   = writeData[23:0];
    // Left-justify so the first bit to send sits at bit 23.
    wd_load   = wd_data << (5'd24 - wd_count);
    wd_mask   = AFE_COUNT'(1) << wd_lane;
    cmd_ok    = (wd_count != 5'd0) && (wd_count <= 5'd24) &&
                ({30'd0, wd_lane} < 32'(AFE_COUNT));
    half_done = (half_cnt == '0);
  end

  assign status = {busy, overrun, last_lane, 4'b0000, last_data};

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state       <= IDLE;
      half_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      lane_mask   <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      last_lane   <= '0;
      last_data   <= '0;
      AFE_SPI_CLK <= '0;
      AFE_SPI_SDI <= '0;
      AFE_SPI_LE  <= '0;
    end else begin
      if (state != IDLE) begin
        half_cnt <= half_done ? H_LAST : half_cnt - 1'b1;
        if (writeStrobe) overrun <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (writeStrobe && wd_count == 5'd0) begin
            overrun <= 1'b0;
          end else if (writeStrobe && cmd_ok) begin
            state       <= SHIFT_LO;
            half_cnt    <= H_LAST;
            bit_cnt     <= wd_count;
            shreg       <= wd_load;
            lane_mask   <= wd_mask;
            busy        <= 1'b1;
            last_lane   <= wd_lane;
            last_data   <= wd_data;
            AFE_SPI_CLK <= '0;
            AFE_SPI_SDI <= wd_load[23] ? wd_mask : '0;
          end
        end
        SHIFT_LO: begin
          if (half_done) begin
            state       <= SHIFT_HI;
            AFE_SPI_CLK <= lane_mask;
          end
        end
        SHIFT_HI: begin
          if (half_done) begin
            AFE_SPI_CLK <= '0;
            if (bit_cnt > 5'd1) begin
              state       <= SHIFT_LO;
              bit_cnt     <= bit_cnt - 5'd1;
              shreg       <= shreg << 1;
              AFE_SPI_SDI <= shreg[22] ? lane_mask : '0;
            end else begin
              state       <= LE_SETUP;
              AFE_SPI_SDI <= '0;
            end
          end
        end
        LE_SETUP: begin
          if (half_done) begin
            state      <= LATCH;
            AFE_SPI_LE <= lane_mask;
          end
        end
        LATCH: begin
          if (half_done) begin
            state      <= GAP;
            AFE_SPI_LE <= '0;
          end
        end
        GAP: begin
          if (half_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_afe_spi_writer.sv
// Self-checking bench for afe_spi_writer at default rates (H=5).
// Lane waveforms are decoded into bit words and compared to a command model.
module tb_afe_spi_writer;

  localparam int H = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        writeStrobe = 1'b0;
  logic [31:0] writeData = '0;
  logic [31:0] status;
  logic [1:0]  spi_clk;
  logic [1:0]  spi_sdi;
  logic [1:0]  spi_le;

  int checks = 0;
  int errors = 0;

  logic        exp_ovr = 1'b0;
  logic [1:0]  exp_lane = '0;
  logic [23:0] exp_data = '0;

  int          cap_busy;
  int          cap_n;
  logic [23:0] cap_word;
  int          cap_le;
  bit          cap_other;
  bit          cap_to;

  afe_spi_writer dut (
    .sysClk      (clk),
    .sysReset    (rst),
    .writeStrobe (writeStrobe),
    .writeData   (writeData),
    .status      (status),
    .AFE_SPI_CLK (spi_clk),
    .AFE_SPI_SDI (spi_sdi),
    .AFE_SPI_LE  (spi_le)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_status(input logic b);
    return {b, exp_ovr, exp_lane, 4'b0000, exp_data};
  endfunction

  function automatic logic [23:0] exp_word(input logic [23:0] d, input int n);
    logic [23:0] m;
    m = (24'(1) << n) - 24'd1;
    return d & m;
  endfunction

  task automatic strobe(input logic [31:0] cmd);
    writeStrobe = 1'b1;
    writeData   = cmd;
    @(posedge clk);
    #1 writeStrobe = 1'b0;
  endtask

  // Samples each cycle until busy falls, decoding bits on CLK rising edges.
  task automatic capture(input int lane);
    logic prev;
    logic [1:0] sel;
    prev = 1'b0;
    sel = 2'(1) << lane;
    cap_busy = 0; cap_n = 0; cap_word = '0;
    cap_le = 0; cap_other = 0; cap_to = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!status[31]) return;
      cap_busy++;
      if (spi_clk[lane] && !prev) begin
        cap_word = {cap_word[22:0], spi_sdi[lane]};
        cap_n++;
      end
      prev = spi_clk[lane];
      if (spi_le[lane]) cap_le++;
      if (((spi_clk | spi_sdi | spi_le) & ~sel) != 2'b00) cap_other = 1;
    end
    cap_to = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({spi_clk, spi_sdi, spi_le} !== 6'b0) begin
      errors++;
      $display("FAIL reset_pins got %b want 0", {spi_clk, spi_sdi, spi_le});
    end
    checks++;
    if (status !== 32'h0) begin
      errors++;
      $display("FAIL reset_status got %h want 0", status);
    end
  endtask

  task automatic test_lane0();
    @(negedge clk);
    strobe(32'h0600_002A);
    exp_lane = 2'd0; exp_data = 24'h2A;
    capture(0);
    checks++;
    if (cap_to || cap_busy !== 75) begin
      errors++;
      $display("FAIL t1_busy got %0d want 75", cap_busy);
    end
    checks++;
    if (cap_n !== 6 || cap_word !== 24'h2A) begin
      errors++;
      $display("FAIL t1_bits got %0d/%h want 6/2a", cap_n, cap_word);
    end
    checks++;
    if (cap_le !== H || cap_other) begin
      errors++;
      $display("FAIL t1_le got %0d other %0d want %0d 0", cap_le, cap_other, H);
    end
  endtask

  task automatic test_lane1();
    strobe(32'h4700_0055);
    exp_lane = 2'd1; exp_data = 24'h55;
    capture(1);
    checks++;
    if (cap_to || cap_busy !== 85) begin
      errors++;
      $display("FAIL t2_busy got %0d want 85", cap_busy);
    end
    checks++;
    if (cap_n !== 7 || cap_word !== 24'h55 || cap_other) begin
      errors++;
      $display("FAIL t2_bits got %0d/%h want 7/55", cap_n, cap_word);
    end
    checks++;
    if (status !== exp_status(1'b0)) begin
      errors++;
      $display("FAIL t2_status got %h want %h", status, exp_status(1'b0));
    end
  endtask

  task automatic test_overrun();
    strobe(32'h0600_002A);
    exp_lane = 2'd0; exp_data = 24'h2A;
    fork
      capture(0);
      begin
        repeat (10) @(negedge clk);
        strobe(32'h0600_00FF);
      end
    join
    exp_ovr = 1'b1;
    checks++;
    if (cap_busy !== 75 || cap_n !== 6 || cap_word !== 24'h2A || cap_le !== H) begin
      errors++;
      $display("FAIL t3_wave got %0d %0d %h %0d want 75 6 2a 5",
               cap_busy, cap_n, cap_word, cap_le);
    end
    checks++;
    if (status !== exp_status(1'b0)) begin
      errors++;
      $display("FAIL t3_ovr_set got %h want %h", status, exp_status(1'b0));
    end
    strobe(32'h0000_0000);
    exp_ovr = 1'b0;
    @(negedge clk);
    checks++;
    if (status !== exp_status(1'b0)) begin
      errors++;
      $display("FAIL t3_ovr_clr got %h want %h", status, exp_status(1'b0));
    end
  endtask

  task automatic test_invalid();
    int bad;
    logic [31:0] cmds [2];
    cmds[0] = 32'h1900_0001;
    cmds[1] = 32'h8600_0001;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      strobe(cmds[c]);
      bad = 0;
      repeat (20) begin
        @(negedge clk);
        if ({spi_clk, spi_sdi, spi_le} != 6'b0 || status !== exp_status(1'b0))
          bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL t4_ignore cmd %h got %0d bad cycles want 0", cmds[c], bad);
      end
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    strobe(32'h0600_002A);
    fork
      capture(0);
      begin
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    exp_ovr = 1'b0; exp_lane = '0; exp_data = '0;
    checks++;
    if (cap_le !== 0 || cap_busy >= 75) begin
      errors++;
      $display("FAIL t5_abort got le %0d busy %0d want 0 <75", cap_le, cap_busy);
    end
    checks++;
    if ({spi_clk, spi_sdi, spi_le} !== 6'b0 || status !== 32'h0) begin
      errors++;
      $display("FAIL t5_clear got %b %h want 0 0", {spi_clk, spi_sdi, spi_le}, status);
    end
    strobe(32'h4700_0055);
    exp_lane = 2'd1; exp_data = 24'h55;
    capture(1);
    checks++;
    if (cap_busy !== 85 || cap_word !== 24'h55 || cap_le !== H) begin
      errors++;
      $display("FAIL t5_after got %0d %h %0d want 85 55 5", cap_busy, cap_word, cap_le);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    strobe(32'h4300_0005);
    capture(1);
    strobe(32'h0400_000A);
    exp_lane = 2'd0; exp_data = 24'h0A;
    capture(0);
    checks++;
    if (cap_to || cap_busy !== H * 11 || cap_n !== 4 || cap_word !== 24'hA) begin
      errors++;
      $display("FAIL t6_b2b got %0d %0d %h want %0d 4 a", cap_busy, cap_n, cap_word, H * 11);
    end
    checks++;
    if (status !== exp_status(1'b0)) begin
      errors++;
      $display("FAIL t6_status got %h want %h", status, exp_status(1'b0));
    end
  endtask

  task automatic test_random();
    int lane, n, want_busy;
    logic [23:0] d;
    for (int k = 0; k < 8; k++) begin
      lane = $urandom_range(0, 1);
      n    = $urandom_range(1, 24);
      d    = 24'($urandom);
      @(negedge clk);
      strobe({2'(lane), 1'($urandom), 5'(n), d});
      exp_lane = 2'(lane); exp_data = d;
      want_busy = H * (2 * n + 3);
      capture(lane);
      checks++;
      if (cap_to || cap_busy !== want_busy || cap_le !== H || cap_other) begin
        errors++;
        $display("FAIL rnd%0d_timing got %0d le %0d other %0d want %0d %0d 0",
                 k, cap_busy, cap_le, cap_other, want_busy, H);
      end
      checks++;
      if (cap_n !== n || cap_word !== exp_word(d, n)) begin
        errors++;
        $display("FAIL rnd%0d_bits got %0d/%h want %0d/%h",
                 k, cap_n, cap_word, n, exp_word(d, n));
      end
      checks++;
      if (status !== exp_status(1'b0)) begin
        errors++;
        $display("FAIL rnd%0d_status got %h want %h", k, status, exp_status(1'b0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_lane0();
    test_lane1();
    test_overrun();
    test_invalid();
    test_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
